// File: rtl/rob_pkg.sv
// Shared types and default sizing for the reorder buffer (rob_param).
package rob_pkg;

    localparam int unsigned ROB_DEPTH_DEF    = 32;
    localparam int unsigned ROB_DATA_W_DEF   = 32;
    localparam int unsigned ROB_ARCH_W_DEF   = 5;
    localparam int unsigned ROB_WB_PORTS_DEF = 4;

    typedef enum logic [1:0] {
        KIND_INT = 2'd0,
        KIND_FP  = 2'd1,
        KIND_SW  = 2'd2,
        KIND_BR  = 2'd3
    } rob_kind_e;

    // Control/status part of an entry; dst and data are sized by the
    // instantiating module and held in parallel arrays.
    typedef struct packed {
        logic      valid;
        logic      done;
        rob_kind_e kind;
        logic      pred;
        logic      taken;
    } rob_entry_t;

    function automatic logic is_mispredict(input rob_entry_t e);
        return (e.kind == KIND_BR) && (e.pred != e.taken);
    endfunction

endpackage

// File: rtl/rob_wb_merge.sv
// Per-entry merge of all writeback ports; the highest-numbered matching port wins.
module rob_wb_merge #(
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ARCH_W   = 5,
    parameter int unsigned WB_PORTS = 4,
    parameter int unsigned TAG_W    = $clog2(DEPTH)
) (
    input  logic [WB_PORTS-1:0]             i_valid,
    input  logic [WB_PORTS-1:0][TAG_W-1:0]  i_tag,
    input  logic [WB_PORTS-1:0][ARCH_W-1:0] i_dst,
    input  logic [WB_PORTS-1:0][DATA_W-1:0] i_data,
    output logic [DEPTH-1:0]                o_hit,
    output logic [DEPTH-1:0][ARCH_W-1:0]    o_dst,
    output logic [DEPTH-1:0][DATA_W-1:0]    o_data
);

    always_comb begin
        o_hit  = '0;
        o_dst  = '0;
        o_data = '0;
        for (int unsigned e = 0; e < DEPTH; e++) begin
            for (int unsigned p = 0; p < WB_PORTS; p++) begin
                if (i_valid[p] && (i_tag[p] == TAG_W'(e))) begin
                    o_hit[e]  = 1'b1;
                    o_dst[e]  = i_dst[p];
                    o_data[e] = i_data[p];
                end
            end
        end
    end

endmodule

// File: rtl/rob_param.sv
// Two-wide dispatch/commit reorder buffer with multi-port writeback and operand lookup.
// Optional macro ROB_FLUSH_EN: a committed mispredicted branch flushes all younger entries.
module rob_param
    import rob_pkg::*;
#(
    parameter int unsigned DEPTH    = ROB_DEPTH_DEF,
    parameter int unsigned DATA_W   = ROB_DATA_W_DEF,
    parameter int unsigned ARCH_W   = ROB_ARCH_W_DEF,
    parameter int unsigned WB_PORTS = ROB_WB_PORTS_DEF,
    parameter int unsigned TAG_W    = $clog2(DEPTH)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [1:0]                      disp_valid,
    input  logic [1:0][1:0]                 disp_kind,
    output logic                            disp_ready,
    output logic [1:0][TAG_W-1:0]           disp_tag,
    input  logic [WB_PORTS-1:0]             wb_valid,
    input  logic [WB_PORTS-1:0][TAG_W-1:0]  wb_tag,
    input  logic [WB_PORTS-1:0][ARCH_W-1:0] wb_dst,
    input  logic [WB_PORTS-1:0][DATA_W-1:0] wb_data,
    input  logic                            br_valid,
    input  logic [TAG_W-1:0]                br_tag,
    input  logic                            br_pred,
    input  logic                            br_taken,
    output logic [1:0]                      cm_valid,
    output logic [1:0][1:0]                 cm_kind,
    output logic [1:0][ARCH_W-1:0]          cm_dst,
    output logic [1:0][DATA_W-1:0]          cm_data,
    output logic [1:0]                      cm_mispredict,
    output logic                            cm_flush,
    input  logic [3:0][TAG_W-1:0]           rd_tag,
    output logic [3:0][DATA_W-1:0]          rd_data,
    output logic [3:0]                      rd_ready,
    output logic [TAG_W:0]                  count,
    output logic                            full,
    output logic                            empty
);

    rob_entry_t        r_ent  [DEPTH];
    logic [ARCH_W-1:0] r_dst  [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [TAG_W-1:0]  r_head;
    logic [TAG_W-1:0]  r_tail;
    logic [TAG_W:0]    r_count;

    logic [DEPTH-1:0]             w_wb_hit;
    logic [DEPTH-1:0][ARCH_W-1:0] w_wb_dst;
    logic [DEPTH-1:0][DATA_W-1:0] w_wb_data;

    logic [TAG_W-1:0] w_head1;
    logic [TAG_W-1:0] w_tail1;
    rob_entry_t       w_e0;
    rob_entry_t       w_e1;
    logic             w_mp0;
    logic             w_mp1;
    logic             w_cm0;
    logic             w_cm1;
    logic             w_flush;
    logic             w_alloc0;
    logic             w_alloc1;
    logic [TAG_W:0]   w_n_cm;
    logic [TAG_W:0]   w_n_al;

    rob_wb_merge #(
        .DEPTH    (DEPTH),
        .DATA_W   (DATA_W),
        .ARCH_W   (ARCH_W),
        .WB_PORTS (WB_PORTS),
        .TAG_W    (TAG_W)
    ) u_wb_merge (
        .i_valid (wb_valid),
        .i_tag   (wb_tag),
        .i_dst   (wb_dst),
        .i_data  (wb_data),
        .o_hit   (w_wb_hit),
        .o_dst   (w_wb_dst),
        .o_data  (w_wb_data)
    );

    assign w_head1 = r_head + TAG_W'(1);
    assign w_tail1 = r_tail + TAG_W'(1);
    assign w_e0    = r_ent[r_head];
    assign w_e1    = r_ent[w_head1];
    assign w_mp0   = is_mispredict(w_e0);
    assign w_mp1   = is_mispredict(w_e1);

    assign disp_ready = (r_count <= (TAG_W+1)'(DEPTH - 2));
    assign disp_tag   = {w_tail1, r_tail};
    assign count      = r_count;
    assign full       = (r_count == (TAG_W+1)'(DEPTH));
    assign empty      = (r_count == '0);

    // Commit decision; a flushing branch stops the younger slot and any dispatch.
    always_comb begin
        w_cm0   = w_e0.valid & w_e0.done;
        w_cm1   = w_cm0 & w_e1.valid & w_e1.done;
        w_flush = 1'b0;
`ifdef ROB_FLUSH_EN
        if (w_cm0 && w_mp0) begin
            w_cm1   = 1'b0;
            w_flush = 1'b1;
        end else if (w_cm1 && w_mp1) begin
            w_flush = 1'b1;
        end
`endif
        w_alloc0 = disp_valid[0] & disp_ready & ~w_flush;
        w_alloc1 = w_alloc0 & disp_valid[1];
        w_n_cm   = (TAG_W+1)'(w_cm0) + (TAG_W+1)'(w_cm1);
        w_n_al   = (TAG_W+1)'(w_alloc0) + (TAG_W+1)'(w_alloc1);
    end

    assign cm_valid      = {w_cm1, w_cm0};
    assign cm_mispredict = {w_cm1 & w_mp1, w_cm0 & w_mp0};
    assign cm_flush      = w_flush;
    assign cm_kind       = {w_e1.kind, w_e0.kind};
    assign cm_dst        = {r_dst[w_head1], r_dst[r_head]};
    assign cm_data       = {r_data[w_head1], r_data[r_head]};

    always_comb begin
        rd_data  = '0;
        rd_ready = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            rd_data[k]  = r_data[rd_tag[k]];
            rd_ready[k] = r_ent[rd_tag[k]].valid & r_ent[rd_tag[k]].done;
        end
    end

    // Later assignments take precedence: completion, then commit, then allocate, then flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_ent[i]  <= '0;
                r_dst[i]  <= '0;
                r_data[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (r_ent[i].valid) begin
                    if (w_wb_hit[i]) begin
                        r_ent[i].done <= 1'b1;
                        r_dst[i]      <= w_wb_dst[i];
                        r_data[i]     <= w_wb_data[i];
                    end
                    if (br_valid && (br_tag == TAG_W'(i))) begin
                        r_ent[i].done  <= 1'b1;
                        r_ent[i].pred  <= br_pred;
                        r_ent[i].taken <= br_taken;
                    end
                end
            end
            if (w_cm0) begin
                r_ent[r_head].valid <= 1'b0;
                r_ent[r_head].done  <= 1'b0;
            end
            if (w_cm1) begin
                r_ent[w_head1].valid <= 1'b0;
                r_ent[w_head1].done  <= 1'b0;
            end
            if (w_alloc0) begin
                r_ent[r_tail]  <= '{valid: 1'b1, done: 1'b0, kind: rob_kind_e'(disp_kind[0]),
                                   pred: 1'b0, taken: 1'b0};
                r_dst[r_tail]  <= '0;
                r_data[r_tail] <= '0;
            end
            if (w_alloc1) begin
                r_ent[w_tail1]  <= '{valid: 1'b1, done: 1'b0, kind: rob_kind_e'(disp_kind[1]),
                                    pred: 1'b0, taken: 1'b0};
                r_dst[w_tail1]  <= '0;
                r_data[w_tail1] <= '0;
            end
            if (w_flush) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    r_ent[i].valid <= 1'b0;
                    r_ent[i].done  <= 1'b0;
                end
            end
            r_head  <= r_head + TAG_W'(w_n_cm);
            r_tail  <= w_flush ? (r_head + TAG_W'(w_n_cm)) : (r_tail + TAG_W'(w_n_al));
            r_count <= w_flush ? '0 : (r_count + w_n_al - w_n_cm);
        end
    end

endmodule

// File: tb/tb_rob_param.sv
// Directed self-checking bench for rob_param; covers the ROB_FLUSH_EN build when that macro is defined.
module tb_rob_param;
    import rob_pkg::*;

    localparam int unsigned DEPTH    = 32;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ARCH_W   = 5;
    localparam int unsigned WB_PORTS = 4;
    localparam int unsigned TAG_W    = 5;

    logic                            clk;
    logic                            rst;
    logic [1:0]                      disp_valid;
    logic [1:0][1:0]                 disp_kind;
    logic                            disp_ready;
    logic [1:0][TAG_W-1:0]           disp_tag;
    logic [WB_PORTS-1:0]             wb_valid;
    logic [WB_PORTS-1:0][TAG_W-1:0]  wb_tag;
    logic [WB_PORTS-1:0][ARCH_W-1:0] wb_dst;
    logic [WB_PORTS-1:0][DATA_W-1:0] wb_data;
    logic                            br_valid;
    logic [TAG_W-1:0]                br_tag;
    logic                            br_pred;
    logic                            br_taken;
    logic [1:0]                      cm_valid;
    logic [1:0][1:0]                 cm_kind;
    logic [1:0][ARCH_W-1:0]          cm_dst;
    logic [1:0][DATA_W-1:0]          cm_data;
    logic [1:0]                      cm_mispredict;
    logic                            cm_flush;
    logic [3:0][TAG_W-1:0]           rd_tag;
    logic [3:0][DATA_W-1:0]          rd_data;
    logic [3:0]                      rd_ready;
    logic [TAG_W:0]                  count;
    logic                            full;
    logic                            empty;

    int n_cmp  = 0;
    int n_fail = 0;
    int h;

    rob_param #(
        .DEPTH    (DEPTH),
        .DATA_W   (DATA_W),
        .ARCH_W   (ARCH_W),
        .WB_PORTS (WB_PORTS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .disp_valid    (disp_valid),
        .disp_kind     (disp_kind),
        .disp_ready    (disp_ready),
        .disp_tag      (disp_tag),
        .wb_valid      (wb_valid),
        .wb_tag        (wb_tag),
        .wb_dst        (wb_dst),
        .wb_data       (wb_data),
        .br_valid      (br_valid),
        .br_tag        (br_tag),
        .br_pred       (br_pred),
        .br_taken      (br_taken),
        .cm_valid      (cm_valid),
        .cm_kind       (cm_kind),
        .cm_dst        (cm_dst),
        .cm_data       (cm_data),
        .cm_mispredict (cm_mispredict),
        .cm_flush      (cm_flush),
        .rd_tag        (rd_tag),
        .rd_data       (rd_data),
        .rd_ready      (rd_ready),
        .count         (count),
        .full          (full),
        .empty         (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        disp_valid = '0;
        disp_kind  = '0;
        wb_valid   = '0;
        wb_tag     = '0;
        wb_dst     = '0;
        wb_data    = '0;
        br_valid   = 1'b0;
        br_tag     = '0;
        br_pred    = 1'b0;
        br_taken   = 1'b0;
    endtask

    task automatic disp(input logic [1:0] v, input rob_kind_e k0, input rob_kind_e k1);
        disp_valid   = v;
        disp_kind[0] = k0;
        disp_kind[1] = k1;
    endtask

    task automatic wb(input int p, input int t, input int d, input logic [31:0] data);
        wb_valid[p] = 1'b1;
        wb_tag[p]   = TAG_W'(t);
        wb_dst[p]   = ARCH_W'(d);
        wb_data[p]  = data;
    endtask

    initial begin
        rst    = 1'b0;
        rd_tag = '0;
        idle();
        #2;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_ready", 64'(disp_ready), 64'd1);
        chk("rst_tag0", 64'(disp_tag[0]), 64'd0);
        chk("rst_tag1", 64'(disp_tag[1]), 64'd1);
        chk("rst_cmv", 64'(cm_valid), 64'd0);
        chk("rst_cmmp", 64'(cm_mispredict), 64'd0);
        chk("rst_flush", 64'(cm_flush), 64'd0);
        chk("rst_rdrdy", 64'(rd_ready), 64'd0);
        step();
        rst = 1'b1;
        step();
        chk("rel_cmv", 64'(cm_valid), 64'd0);

        // Two INT entries completed out of order commit together in order
        disp(2'b11, KIND_INT, KIND_INT);
        chk("pair_tag0", 64'(disp_tag[0]), 64'd0);
        chk("pair_tag1", 64'(disp_tag[1]), 64'd1);
        step(); idle();
        chk("pair_count", 64'(count), 64'd2);
        wb(0, 1, 3, 32'hA);
        rd_tag[0] = 5'd1;
        step(); idle();
        chk("pair_cmv_wait", 64'(cm_valid), 64'd0);
        chk("pair_rd_rdy", 64'(rd_ready[0]), 64'd1);
        chk("pair_rd_data", 64'(rd_data[0]), 64'hA);
        wb(0, 0, 4, 32'hB);
        chk("pair_nobypass", 64'(cm_valid), 64'd0);
        step(); idle();
        chk("pair_cmv", 64'(cm_valid), 64'd3);
        chk("pair_d0", 64'(cm_data[0]), 64'hB);
        chk("pair_d1", 64'(cm_data[1]), 64'hA);
        chk("pair_dst0", 64'(cm_dst[0]), 64'd4);
        chk("pair_dst1", 64'(cm_dst[1]), 64'd3);
        chk("pair_kind0", 64'(cm_kind[0]), 64'(KIND_INT));
        step();
        chk("pair_empty", 64'(empty), 64'd1);
        chk("pair_cmv_after", 64'(cm_valid), 64'd0);

        // Writeback port priority and writeback to an invalid entry
        disp(2'b11, KIND_INT, KIND_INT); step();
        disp(2'b11, KIND_INT, KIND_SW);  step(); idle();
        chk("prio_count", 64'(count), 64'd4);
        wb(0, 5, 7, 32'h11);
        wb(3, 5, 9, 32'h33);
        wb(1, 10, 1, 32'h77);
        rd_tag[0] = 5'd5; rd_tag[1] = 5'd10; rd_tag[2] = 5'd4;
        step(); idle();
        chk("prio_rd_data", 64'(rd_data[0]), 64'h33);
        chk("prio_rd_rdy", 64'(rd_ready[0]), 64'd1);
        chk("inv_rd_rdy", 64'(rd_ready[1]), 64'd0);
        chk("inv_rd_data", 64'(rd_data[1]), 64'd0);
        chk("pend_rd_rdy", 64'(rd_ready[2]), 64'd0);
        chk("prio_cmv", 64'(cm_valid), 64'd0);
        wb(0, 2, 1, 32'h22); wb(1, 3, 2, 32'h23); wb(2, 4, 3, 32'h24);
        step(); idle();
        chk("prio_cmv2", 64'(cm_valid), 64'd3);
        chk("prio_c0", 64'(cm_data[0]), 64'h22);
        chk("prio_c1", 64'(cm_data[1]), 64'h23);
        step();
        chk("prio_cmv3", 64'(cm_valid), 64'd3);
        chk("prio_c2", 64'(cm_data[0]), 64'h24);
        chk("prio_c3", 64'(cm_data[1]), 64'h33);
        chk("prio_dst3", 64'(cm_dst[1]), 64'd9);
        chk("prio_kind3", 64'(cm_kind[1]), 64'(KIND_SW));
        step();
        chk("prio_empty", 64'(empty), 64'd1);

        // Fill to capacity from head=tail=6
        for (int i = 0; i < 15; i++) begin
            disp(2'b11, KIND_INT, KIND_INT);
            step();
        end
        idle();
        chk("fill30_count", 64'(count), 64'd30);
        chk("fill30_ready", 64'(disp_ready), 64'd1);
        chk("fill30_tag", 64'(disp_tag[0]), 64'd4);
        disp(2'b01, KIND_INT, KIND_INT); step(); idle();
        chk("fill31_count", 64'(count), 64'd31);
        chk("fill31_ready", 64'(disp_ready), 64'd0);
        chk("fill31_full", 64'(full), 64'd0);
        disp(2'b11, KIND_INT, KIND_INT); step(); idle();
        chk("fill31_ign_count", 64'(count), 64'd31);
        chk("fill31_ign_tag", 64'(disp_tag[0]), 64'd5);
        wb(0, 6, 1, 32'h60); step(); idle();
        chk("fill31_cmv", 64'(cm_valid), 64'd1);
        chk("fill31_cmd", 64'(cm_data[0]), 64'h60);
        disp(2'b11, KIND_INT, KIND_INT); step(); idle();
        chk("fill_commit_count", 64'(count), 64'd30);
        chk("fill_commit_tag", 64'(disp_tag[0]), 64'd5);
        disp(2'b11, KIND_INT, KIND_INT); step(); idle();
        chk("full_count", 64'(count), 64'd32);
        chk("full_flag", 64'(full), 64'd1);
        chk("full_ready", 64'(disp_ready), 64'd0);
        chk("full_empty", 64'(empty), 64'd0);
        chk("full_tag", 64'(disp_tag[0]), 64'd7);
        disp(2'b11, KIND_INT, KIND_INT); wb(0, 7, 1, 32'h70); step(); idle();
        chk("full_ign_count", 64'(count), 64'd32);
        chk("full_cmv", 64'(cm_valid), 64'd1);
        disp(2'b11, KIND_INT, KIND_INT); step(); idle();
        chk("full_commit_count", 64'(count), 64'd31);
        chk("full_commit_full", 64'(full), 64'd0);
        wb(0, 8, 1, 32'h80); step(); idle(); step();
        chk("drop30_count", 64'(count), 64'd30);
        wb(0, 9, 1, 32'h90); step(); idle();
        chk("hold_cmv", 64'(cm_valid), 64'd1);
        disp(2'b01, KIND_INT, KIND_INT); step(); idle();
        chk("hold_count", 64'(count), 64'd30);
        chk("hold_tag", 64'(disp_tag[0]), 64'd8);

        // Drain in order: tags 10..31 then 0..7
        for (int k = 0; k < 30; k++) begin
            wb(0, (10 + k) % 32, k % 32, 32'h1000 + 32'(k));
            step(); idle();
            chk("drain_cmv", 64'(cm_valid), 64'd1);
            chk("drain_data", 64'(cm_data[0]), 64'h1000 + 64'(k));
            step();
        end
        chk("drain_empty", 64'(empty), 64'd1);

        // 40 single allocate/commit rounds from tag 8, wrapping 31->0
        for (int k = 0; k < 40; k++) begin
            chk("wrap_tag", 64'(disp_tag[0]), 64'((8 + k) % 32));
            disp(2'b01, KIND_FP, KIND_INT); step(); idle();
            wb(2, (8 + k) % 32, k % 32, 32'h2000 + 32'(k)); step(); idle();
            chk("wrap_cmv", 64'(cm_valid), 64'd1);
            chk("wrap_data", 64'(cm_data[0]), 64'h2000 + 64'(k));
            chk("wrap_kind", 64'(cm_kind[0]), 64'(KIND_FP));
            step();
        end
        chk("wrap_empty", 64'(empty), 64'd1);

        // Mispredicted branch at head (tag 16) with three done younger entries
        disp(2'b11, KIND_BR, KIND_INT); step();
        disp(2'b11, KIND_INT, KIND_INT); step(); idle();
        br_valid = 1'b1; br_tag = 5'd16; br_pred = 1'b1; br_taken = 1'b0;
        wb(0, 17, 1, 32'h171); wb(1, 18, 2, 32'h181); wb(2, 19, 3, 32'h191);
        step(); idle();
`ifdef ROB_FLUSH_EN
        chk("fl_cmv", 64'(cm_valid), 64'd1);
        chk("fl_mp", 64'(cm_mispredict), 64'd1);
        chk("fl_flush", 64'(cm_flush), 64'd1);
        chk("fl_kind", 64'(cm_kind[0]), 64'(KIND_BR));
        disp(2'b11, KIND_INT, KIND_INT); step(); idle();
        chk("fl_count", 64'(count), 64'd0);
        chk("fl_empty", 64'(empty), 64'd1);
        chk("fl_flush_off", 64'(cm_flush), 64'd0);
        chk("fl_cmv_after", 64'(cm_valid), 64'd0);
        chk("fl_tail", 64'(disp_tag[0]), 64'd17);
        h = 17;
`else
        chk("mp_cmv", 64'(cm_valid), 64'd3);
        chk("mp_mp", 64'(cm_mispredict), 64'd1);
        chk("mp_flush", 64'(cm_flush), 64'd0);
        chk("mp_d1", 64'(cm_data[1]), 64'h171);
        step();
        chk("mp_count", 64'(count), 64'd2);
        chk("mp_cmv2", 64'(cm_valid), 64'd3);
        chk("mp_mp2", 64'(cm_mispredict), 64'd0);
        chk("mp_d2", 64'(cm_data[0]), 64'h181);
        step();
        chk("mp_empty", 64'(empty), 64'd1);
        h = 20;
`endif

        // Reset mid-stream with seven entries, head ready to commit
        disp(2'b11, KIND_INT, KIND_INT); step();
        disp(2'b11, KIND_INT, KIND_INT); step();
        disp(2'b11, KIND_INT, KIND_INT); step();
        disp(2'b01, KIND_INT, KIND_INT); step(); idle();
        wb(0, h, 1, 32'h55); step(); idle();
        chk("mid_count", 64'(count), 64'd7);
        chk("mid_cmv", 64'(cm_valid), 64'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("mid_rst_count", 64'(count), 64'd0);
        chk("mid_rst_empty", 64'(empty), 64'd1);
        chk("mid_rst_cmv", 64'(cm_valid), 64'd0);
        chk("mid_rst_tag0", 64'(disp_tag[0]), 64'd0);
        chk("mid_rst_tag1", 64'(disp_tag[1]), 64'd1);
        step();
        #2;
        rst = 1'b1;
        step();
        chk("mid_rel_cmv", 64'(cm_valid), 64'd0);
        chk("mid_rel_count", 64'(count), 64'd0);
        disp(2'b01, KIND_INT, KIND_INT); step(); idle();
        chk("mid_new_cmv", 64'(cm_valid), 64'd0);
        chk("mid_new_count", 64'(count), 64'd1);
        wb(0, 0, 2, 32'h5A); step(); idle();
        chk("mid_new_cmv2", 64'(cm_valid), 64'd1);
        chk("mid_new_data", 64'(cm_data[0]), 64'h5A);
        step();
        chk("mid_new_empty", 64'(empty), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
